isqrt_seq: RTL and testbench

ISQRT_SEQ -- requirements
Module: isqrt_seq

---
 rtl/isqrt_seq.sv | 116 +++++++++++
 tb/tb_isqrt_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/isqrt_seq.sv
// Sequential restoring integer square root: one result bit per enabled clock.
// Define ISQRT_ROUND_EN to round the result to nearest (saturating) instead of flooring.
module isqrt_seq #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      en,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2*DATA_WIDTH-1:0]   xin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     yout
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [2*W-1:0] x_q, x_d;
  logic [W+1:0]   rem_q, rem_d;
  logic [W-1:0]   root_q, root_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   yout_q, yout_d;

  // One digit step, evaluated two bits wider than the remainder so nothing is truncated.
  logic [W+3:0] rem_sh, trial, diff;
  logic         rem_ge;
  logic [W-1:0] root_step;
  logic [W+1:0] rem_step;
  logic [W-1:0] result;
  logic         unused_diff;

  assign rem_sh      = {rem_q, x_q[2*W-1 -: 2]};
  assign trial       = {2'b00, root_q, 2'b01};
  assign diff        = rem_sh - trial;
  assign rem_ge      = (rem_sh >= trial);
  assign root_step   = {root_q[W-2:0], rem_ge};
  assign rem_step    = rem_ge ? diff[W+1:0] : rem_sh[W+1:0];
  assign unused_diff = ^diff[W+3:W+2];

`ifdef ISQRT_ROUND_EN
  logic round_up;
  assign round_up = (rem_step > {2'b00, root_step}) && !(&root_step);
  assign result   = round_up ? root_step + {{(W-1){1'b0}}, 1'b1} : root_step;
`else
  assign result = root_step;
`endif

  // NOTE: every always_comb output starts from a default so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    yout_d  = yout_q;
    if (en) begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            x_d     = xin;
            rem_d   = '0;
            root_d  = '0;
            cnt_d   = CW'(W - 1);
            state_d = S_CALC;
          end
        end
        S_CALC: begin
          x_d    = x_q << 2;
          rem_d  = rem_step;
          root_d = root_step;
          if (cnt_q == '0) begin
            yout_d  = result;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      yout_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
      yout_q  <= yout_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign yout      = yout_q;

endmodule

// File: tb/tb_isqrt_seq.sv
// Self-checking bench for isqrt_seq (DATA_WIDTH=16) against a binary-search square-root model.
// Honours ISQRT_ROUND_EN in the model so the same bench covers both builds.
module tb_isqrt_seq;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rstn;
  logic           en;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] xin;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   yout;

  int n_tests = 0;
  int n_fail  = 0;

  isqrt_seq #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .xin       (xin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .yout      (yout)
  );

  always #5 clk = ~clk;

  // Reference: largest r with r*r <= x, then optional round-up when x - r*r > r.
  function automatic longint unsigned ref_sqrt(input longint unsigned x);
    longint unsigned lo, hi, mid;
    lo = 0;
    hi = (64'd1 << W) - 1;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= x) lo = mid;
      else hi = mid - 1;
    end
`ifdef ISQRT_ROUND_EN
    if ((x - lo * lo) > lo && lo < ((64'd1 << W) - 1)) lo = lo + 1;
`endif
    return lo;
  endfunction

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_tests++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: optional en-low pause mid-CALC and optional DONE hold with out_ready low.
  task automatic run_op(input logic [2*W-1:0] x, input int pause, input int hold);
    logic [W-1:0] expv;
    int           n;
    int           lat;
    expv = W'(ref_sqrt(64'(x)));
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_wait", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    xin      = x;
    tick();
    check("accepted", 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      in_valid = 1'($urandom_range(0, 1));
      xin      = $urandom;
      if (lat == 5 && pause > 0) begin
        en = 1'b0;
        repeat (pause) begin
          tick();
          check("en_low_no_valid", 64'(out_valid), 64'd0);
        end
        en = 1'b1;
      end
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check("latency", 64'(lat), 64'(W));
    check("out_valid", 64'(out_valid), 64'd1);
    check("yout", 64'(yout), 64'(expv));
    if (hold > 0) begin
      repeat (hold) begin
        in_valid = 1'b1;
        xin      = $urandom;
        tick();
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_yout", 64'(yout), 64'(expv));
        check("hold_in_ready", 64'(in_ready), 64'd0);
      end
      in_valid  = 1'b0;
      en        = 1'b0;
      out_ready = 1'b1;
      tick();
      check("en_low_no_handshake", 64'(out_valid), 64'd1);
      out_ready = 1'b0;
      en        = 1'b1;
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    xin       = $urandom;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("exit_valid_low", 64'(out_valid), 64'd0);
    check("exit_no_overlap", 64'(in_ready), 64'd1);
    check("yout_retained", 64'(yout), 64'(expv));
  endtask

  initial begin
    int spurious;
    rstn      = 1'b0;
    en        = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    xin       = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_yout", 64'(yout), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    run_op(32'd0, 0, 0);
    run_op(32'd144, 0, 0);
    run_op(32'd156, 0, 0);
    run_op(32'd157, 0, 0);
    run_op(32'hFFFF_FFFF, 0, 0);
    run_op(32'hFFFE_0001, 0, 0);
    run_op(32'd1000000, 3, 0);
    run_op(32'd625, 0, 5);
    run_op(32'd3, 0, 0);

    // Abort mid-calculation with an asynchronous reset.
    in_valid = 1'b1;
    xin      = 32'h1234_5678;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    rstn = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_yout", 64'(yout), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rstn = 1'b1;
    spurious = 0;
    repeat (30) begin
      tick();
      if (out_valid) spurious++;
    end
    check("abort_no_result", 64'(spurious), 64'd0);
    check("abort_ready_after", 64'(in_ready), 64'd1);
    run_op(32'd81, 0, 0);

    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) run_op($urandom, 0, 0);
      else run_op(32'($urandom_range(0, 70000)), i % 3, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
